// File: rtl/snek_pkg.sv
// Shared constants for the snek body engine: direction codes,
// FSM state encoding and default grid/length sizes.
package snek_pkg;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DEAD   = 2'd3
    } state_e;

    localparam int DEF_GRID_W  = 32;
    localparam int DEF_GRID_H  = 24;
    localparam int DEF_MAXLEN  = 64;
    localparam int DEF_CELL_PX = 20;

    // Encoding pairs left/right and down/up on bit 0.
    function automatic logic [1:0] dir_opposite(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction

endpackage

// File: rtl/snek_ring_buf.sv
// Segment ring buffer: head pointer, segment storage, indexed
// read port for the collision scan and the per-pixel body hit.
module snek_ring_buf
    import snek_pkg::*;
#(
    parameter int GRID_W  = DEF_GRID_W,
    parameter int GRID_H  = DEF_GRID_H,
    parameter int MAXLEN  = DEF_MAXLEN,
    parameter int CELL_PX = DEF_CELL_PX,
    localparam int HW = $clog2(GRID_W),
    localparam int VW = $clog2(GRID_H),
    localparam int PW = $clog2(MAXLEN),
    localparam int LW = $clog2(MAXLEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [HW-1:0] push_h,
    input  logic [VW-1:0] push_v,
    input  logic [PW-1:0] rd_idx,
    input  logic [LW-1:0] length,
    input  logic [9:0]    hpos,
    input  logic [9:0]    vpos,
    output logic [HW-1:0] rd_h,
    output logic [VW-1:0] rd_v,
    output logic [HW-1:0] head_h,
    output logic [VW-1:0] head_v,
    output logic          pix_hit
);

    logic [HW-1:0] seg_h [MAXLEN];
    logic [VW-1:0] seg_v [MAXLEN];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] new_ptr;
    logic [PW-1:0] rd_ptr;
    logic [MAXLEN-1:0] hit;

    assign new_ptr = head_ptr - PW'(1);
    assign rd_ptr  = head_ptr + rd_idx;
    assign rd_h    = seg_h[rd_ptr];
    assign rd_v    = seg_v[rd_ptr];
    assign head_h  = seg_h[head_ptr];
    assign head_v  = seg_v[head_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            for (int i = 0; i < MAXLEN; i++) begin
                seg_h[i] <= HW'(GRID_W / 2 - 1);
                seg_v[i] <= VW'(GRID_H / 2 - 1);
            end
        end else if (push) begin
            head_ptr       <= new_ptr;
            seg_h[new_ptr] <= push_h;
            seg_v[new_ptr] <= push_v;
        end
    end

    // Cell interiors only, so the cell edges render as grid lines.
    for (genvar i = 0; i < MAXLEN; i++) begin : g_seg
        logic [PW-1:0] rel;
        logic [10:0]   x0;
        logic [10:0]   y0;
        logic          live;
        logic          in_x;
        logic          in_y;
        assign rel  = PW'(i) - head_ptr;
        assign live = {1'b0, rel} < length;
        assign x0   = 11'(seg_h[i]) * 11'(CELL_PX);
        assign y0   = 11'(seg_v[i]) * 11'(CELL_PX);
        assign in_x = ({1'b0, hpos} > x0)
                   && ({1'b0, hpos} < x0 + 11'(CELL_PX));
        assign in_y = ({1'b0, vpos} > y0)
                   && ({1'b0, vpos} < y0 + 11'(CELL_PX));
        assign hit[i] = live && in_x && in_y;
    end

    assign pix_hit = |hit;

endmodule

// File: rtl/snek_body_engine.sv
// Snek body engine: step-driven move FSM with serial self-collision scan.
// Define SNEK_WRAP_EN to wrap at the grid edges instead of dying.
module snek_body_engine
    import snek_pkg::*;
#(
    parameter int GRID_W  = DEF_GRID_W,
    parameter int GRID_H  = DEF_GRID_H,
    parameter int MAXLEN  = DEF_MAXLEN,
    parameter int CELL_PX = DEF_CELL_PX
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step,
    input  logic                         run,
    input  logic [1:0]                   dir,
    input  logic                         grow,
    input  logic [9:0]                   hpos,
    input  logic [9:0]                   vpos,
    output logic                         snek_loc,
    output logic [$clog2(GRID_W)-1:0]    head_h,
    output logic [$clog2(GRID_H)-1:0]    head_v,
    output logic [$clog2(MAXLEN+1)-1:0]  length,
    output logic                         busy,
    output logic                         dead,
    output logic                         full
);

    localparam int HW = $clog2(GRID_W);
    localparam int VW = $clog2(GRID_H);
    localparam int PW = $clog2(MAXLEN);
    localparam int LW = $clog2(MAXLEN + 1);

    state_e        state;
    logic [1:0]    last_dir;
    logic [1:0]    nxt_dir;
    logic [1:0]    eff_dir;
    logic          grow_pend;
    logic [LW-1:0] len_q;
    logic [HW-1:0] nxt_h;
    logic [VW-1:0] nxt_v;
    logic          oob;
    logic [PW-1:0] scan_k;
    logic [HW-1:0] cand_h;
    logic [VW-1:0] cand_v;
    logic          cand_oob;
    logic          wall_hit;
    logic [HW-1:0] rd_h;
    logic [VW-1:0] rd_v;
    logic          is_tail;
    logic          tail_skip;
    logic          hit;

    assign eff_dir = (len_q > LW'(1) && dir == dir_opposite(last_dir))
                   ? last_dir : dir;

    always_comb begin
        cand_h   = head_h;
        cand_v   = head_v;
        cand_oob = 1'b0;
        case (eff_dir)
            DIR_LEFT:
                if (head_h == '0) begin
                    cand_oob = 1'b1;
                    cand_h   = HW'(GRID_W - 1);
                end else cand_h = head_h - 1'b1;
            DIR_RIGHT:
                if (head_h == HW'(GRID_W - 1)) begin
                    cand_oob = 1'b1;
                    cand_h   = '0;
                end else cand_h = head_h + 1'b1;
            DIR_DOWN:
                if (head_v == VW'(GRID_H - 1)) begin
                    cand_oob = 1'b1;
                    cand_v   = '0;
                end else cand_v = head_v + 1'b1;
            default:
                if (head_v == '0) begin
                    cand_oob = 1'b1;
                    cand_v   = VW'(GRID_H - 1);
                end else cand_v = head_v - 1'b1;
        endcase
    end

`ifdef SNEK_WRAP_EN
    assign wall_hit = 1'b0;
`else
    assign wall_hit = cand_oob;
`endif

    // The tail cell is vacated by this move unless the body actually grows.
    assign is_tail   = {1'b0, scan_k} == len_q - 1'b1;
    assign tail_skip = is_tail && !(grow_pend && !full);
    assign hit       = rd_h == nxt_h && rd_v == nxt_v && !tail_skip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            last_dir <= DIR_RIGHT;
            nxt_dir  <= DIR_RIGHT;
            nxt_h    <= '0;
            nxt_v    <= '0;
            oob      <= 1'b0;
            scan_k   <= '0;
            len_q    <= LW'(1);
        end else begin
            case (state)
                ST_IDLE:
                    if (step && run) begin
                        state   <= ST_SCAN;
                        nxt_h   <= cand_h;
                        nxt_v   <= cand_v;
                        nxt_dir <= eff_dir;
                        oob     <= wall_hit;
                        scan_k  <= '0;
                    end
                ST_SCAN:
                    if (oob || hit) state <= ST_DEAD;
                    else if (is_tail) state <= ST_COMMIT;
                    else scan_k <= scan_k + 1'b1;
                ST_COMMIT: begin
                    last_dir <= nxt_dir;
                    if (grow_pend && !full) len_q <= len_q + 1'b1;
                    state <= ST_IDLE;
                end
                ST_DEAD: state <= ST_DEAD;
            endcase
        end
    end

    // A grow arriving in the consuming cycle stays pending for the next move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) grow_pend <= 1'b0;
        else if (state == ST_COMMIT && grow_pend) grow_pend <= grow;
        else if (grow) grow_pend <= 1'b1;
    end

    snek_ring_buf #(
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .MAXLEN  (MAXLEN),
        .CELL_PX (CELL_PX)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .push    (state == ST_COMMIT),
        .push_h  (nxt_h),
        .push_v  (nxt_v),
        .rd_idx  (scan_k),
        .length  (len_q),
        .hpos    (hpos),
        .vpos    (vpos),
        .rd_h    (rd_h),
        .rd_v    (rd_v),
        .head_h  (head_h),
        .head_v  (head_v),
        .pix_hit (snek_loc)
    );

    assign length = len_q;
    assign busy   = state == ST_SCAN || state == ST_COMMIT;
    assign dead   = state == ST_DEAD;
    assign full   = len_q == LW'(MAXLEN);

endmodule

// File: doc/snek_body_engine.md
SNEK_BODY_ENGINE -- requirements
Module: snek_body_engine

Interface
REQ-001 SHALL have parameter GRID_W, default 32, grid width in cells.
REQ-002 SHALL have parameter GRID_H, default 24, grid height in cells.
REQ-003 SHALL have parameter MAXLEN, default 64, maximum segment count (power of two, >=4).
REQ-004 SHALL have parameter CELL_PX, default 20, cell edge in pixels.
REQ-005 clk  in  1  single system clock, all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 step  in  1  one-cycle move tick (replaces separate frame clock).
REQ-008 run  in  1  steps accepted only when high.
REQ-009 dir  in  2  requested direction: 0 left, 1 right, 2 down, 3 up.
REQ-010 grow  in  1  one-cycle pulse; latched until consumed.
REQ-011 hpos, vpos  in  10 each  current pixel position.
REQ-012 snek_loc  out  1  pixel lies inside any live segment.
REQ-013 head_h, head_v  out  clog2(GRID_W), clog2(GRID_H)  head cell.
REQ-014 length  out  clog2(MAXLEN+1)  live segment count.
REQ-015 busy, dead, full  out  1 each  move in progress; game over; length==MAXLEN.

Function
REQ-016 Segments SHALL be held in a MAXLEN-entry ring buffer; head pointer decrements (mod MAXLEN) on each committed move; segment k is entry (head_ptr+k) mod MAXLEN, live when k<length.
REQ-017 FSM states IDLE, SCAN, COMMIT, DEAD; IDLE->SCAN on step&run&!dead; busy high outside IDLE/DEAD.
REQ-018 On entering SCAN the next-head cell SHALL be computed from effective direction; a dir opposite the last committed direction SHALL be ignored when length>1.
REQ-019 Leaving the grid (h<0, h>=GRID_W, v<0, v>=GRID_H) SHALL go to DEAD next cycle, no commit.
REQ-020 SCAN SHALL compare next head against segments 0..length-1, one per cycle; tail segment excluded unless grow pending; any match -> DEAD, no commit.
REQ-021 COMMIT SHALL write next head, update last direction, and if grow pending and !full increment length and clear pending; grow while full SHALL be cleared without growth; return to IDLE.
REQ-022 Latency step->updated head_h/head_v SHALL be length+2 cycles.
REQ-023 step while busy or DEAD SHALL be ignored; grow pulse in any state SHALL set pending; grow coincident with COMMIT consumption remains pending for next move.
REQ-024 run low SHALL not abort a move already in SCAN.
REQ-025 snek_loc SHALL be combinational: hpos>h*CELL_PX and hpos<(h+1)*CELL_PX and same for vpos, ORed over live segments (boundary pixels excluded, giving grid lines).
REQ-026 DEAD SHALL be left only by rst.

Reset
REQ-027 rst SHALL force: state IDLE, head at (GRID_W/2-1, GRID_H/2-1), length 1, last direction right, grow pending 0, dead 0, busy 0, full 0; asserted mid-SCAN discards the move.

Configuration
REQ-028 Macro SNEK_WRAP_EN defined: off-grid next head wraps modulo GRID_W/GRID_H, never DEAD from walls; undefined: REQ-019 applies.

Structure
REQ-029 Package snek_pkg SHALL hold direction encoding constants, FSM state enum and default grid/length constants.
REQ-030 Sub-module snek_ring_buf SHALL hold segment storage, pointer arithmetic and live-index read port.

Verification
REQ-031 Reset, step with dir=1, run=1 -> head (16,11) after 3 cycles, length 1.
REQ-032 grow then step -> length 2, segment1=(15,11); dir=0 next step -> ignored, head moves right.
REQ-033 Head at (31,y), dir=1, step -> dead=1, head unchanged; with SNEK_WRAP_EN head=(0,y), dead=0.
REQ-034 Build length 5, steer down,left,up into body -> dead=1 on scan hit; step afterwards ignored.
REQ-035 Length MAXLEN, grow+step -> full=1, length stays MAXLEN, pending cleared.
REQ-036 rst asserted during SCAN -> all outputs at reset values next cycle; hpos=310, vpos=230 -> snek_loc=1; hpos=300 -> 0.
